// File: rtl/cdb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter_if
// Description : Producer-side result bus and CDB lane bundle for cdb_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface cdb_arbiter_if #(
    parameter int PREG_BITS = 6,
    parameter int NUM_SRC   = 4,
    parameter int CDB_WIDTH = 2
);
    logic                                 flush;
    logic [NUM_SRC-1:0]                   src_valid;
    logic [NUM_SRC-1:0][PREG_BITS-1:0]    src_prd;
    logic [NUM_SRC-1:0][31:0]             src_data;
    logic [NUM_SRC-1:0][6:0]              src_rob_idx;
    logic [NUM_SRC-1:0]                   src_stall;
    logic [CDB_WIDTH-1:0]                 cdb_valid;
    logic [CDB_WIDTH-1:0][PREG_BITS-1:0]  cdb_prd;
    logic [CDB_WIDTH-1:0][31:0]           cdb_data;
    logic [CDB_WIDTH-1:0][6:0]            cdb_rob_idx;
    logic                                 overflow_err;

    modport master (
        output flush, src_valid, src_prd, src_data, src_rob_idx,
        input  src_stall, cdb_valid, cdb_prd, cdb_data, cdb_rob_idx, overflow_err
    );

    modport slave (
        input  flush, src_valid, src_prd, src_data, src_rob_idx,
        output src_stall, cdb_valid, cdb_prd, cdb_data, cdb_rob_idx, overflow_err
    );
endinterface
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter
// Description : Per-unit result FIFOs with round-robin multi-lane CDB grant.
// Revision    : 1.0 - initial release
// ============================================================================
module cdb_arbiter #(
    parameter int NUM_PHYS_REGS = 64,
    parameter int NUM_SRC       = 4,
    parameter int CDB_WIDTH     = 2,
    parameter int FIFO_DEPTH    = 8,
    parameter int STALL_SLACK   = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    cdb_arbiter_if.slave  bus
);
    localparam int PREG_BITS = $clog2(NUM_PHYS_REGS);
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int SRC_W     = $clog2(NUM_SRC);
    localparam int EW        = PREG_BITS + 32 + 7;
    localparam logic [PTR_W:0] c_STALL_LEVEL = (PTR_W+1)'(FIFO_DEPTH - STALL_SLACK);

    logic [EW-1:0]        r_mem  [NUM_SRC][FIFO_DEPTH];
    logic [PTR_W:0]       r_wptr [NUM_SRC];
    logic [PTR_W:0]       r_rptr [NUM_SRC];
    logic [SRC_W-1:0]     r_rr_ptr;
    logic [CDB_WIDTH-1:0]                r_cdb_valid;
    logic [CDB_WIDTH-1:0][PREG_BITS-1:0] r_cdb_prd;
    logic [CDB_WIDTH-1:0][31:0]          r_cdb_data;
    logic [CDB_WIDTH-1:0][6:0]           r_cdb_rob_idx;
    logic                                r_overflow;

    logic [PTR_W:0]       w_count [NUM_SRC];
    logic [EW-1:0]        w_head  [NUM_SRC];
    logic [NUM_SRC-1:0]   w_empty;
    logic [NUM_SRC-1:0]   w_full;
    logic [NUM_SRC-1:0]   w_grant;
    logic [NUM_SRC-1:0]   w_push;
    logic [SRC_W-1:0]     w_lane_src   [CDB_WIDTH];
    logic [EW-1:0]        w_lane_entry [CDB_WIDTH];
    logic [CDB_WIDTH-1:0] w_lane_valid;
    logic [SRC_W-1:0]     w_rr_next;

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        assign w_count[s] = r_wptr[s] - r_rptr[s];
        assign w_empty[s] = (r_wptr[s] == r_rptr[s]);
        assign w_full[s]  = (r_wptr[s][PTR_W] != r_rptr[s][PTR_W]) &&
                            (r_wptr[s][PTR_W-1:0] == r_rptr[s][PTR_W-1:0]);
        assign w_head[s]  = r_mem[s][r_rptr[s][PTR_W-1:0]];
        // A full FIFO can still accept when its head leaves in the same cycle.
        assign w_push[s]  = bus.src_valid[s] && (!w_full[s] || w_grant[s]);
        assign bus.src_stall[s] = (w_count[s] >= c_STALL_LEVEL);
    end

    for (genvar k = 0; k < CDB_WIDTH; k++) begin : g_lane
        assign w_lane_entry[k] = w_head[w_lane_src[k]];
    end

    always_comb begin
        logic [SRC_W:0]   w_sum;
        logic [SRC_W-1:0] w_idx;
        int               w_ngrant;
        w_grant      = '0;
        w_lane_valid = '0;
        w_rr_next    = r_rr_ptr;
        w_ngrant     = 0;
        w_sum        = '0;
        w_idx        = '0;
        for (int k = 0; k < CDB_WIDTH; k++) begin
            w_lane_src[k] = '0;
        end
        for (int k = 0; k < NUM_SRC; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (SRC_W+1)'(k);
            if (w_sum >= (SRC_W+1)'(NUM_SRC)) begin
                w_sum = w_sum - (SRC_W+1)'(NUM_SRC);
            end
            w_idx = w_sum[SRC_W-1:0];
            if (!w_empty[w_idx] && (w_ngrant < CDB_WIDTH)) begin
                w_grant[w_idx] = 1'b1;
                for (int l = 0; l < CDB_WIDTH; l++) begin
                    if (l == w_ngrant) begin
                        w_lane_valid[l] = 1'b1;
                        w_lane_src[l]   = w_idx;
                    end
                end
                w_ngrant  = w_ngrant + 1;
                w_rr_next = (w_idx == SRC_W'(NUM_SRC - 1)) ? '0 : w_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int s = 0; s < NUM_SRC; s++) begin
            if (!bus.flush && w_push[s]) begin
                r_mem[s][r_wptr[s][PTR_W-1:0]] <= {bus.src_prd[s], bus.src_data[s], bus.src_rob_idx[s]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                r_wptr[s] <= '0;
                r_rptr[s] <= '0;
            end
            r_rr_ptr      <= '0;
            r_cdb_valid   <= '0;
            r_cdb_prd     <= '0;
            r_cdb_data    <= '0;
            r_cdb_rob_idx <= '0;
            r_overflow    <= 1'b0;
        end else if (bus.flush) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                r_wptr[s] <= '0;
                r_rptr[s] <= '0;
            end
            r_rr_ptr      <= '0;
            r_cdb_valid   <= '0;
            r_cdb_prd     <= '0;
            r_cdb_data    <= '0;
            r_cdb_rob_idx <= '0;
        end else begin
            for (int s = 0; s < NUM_SRC; s++) begin
                if (w_push[s])  r_wptr[s] <= r_wptr[s] + 1'b1;
                if (w_grant[s]) r_rptr[s] <= r_rptr[s] + 1'b1;
            end
            if (|(bus.src_valid & ~w_push)) begin
                r_overflow <= 1'b1;
            end
            r_rr_ptr    <= w_rr_next;
            r_cdb_valid <= w_lane_valid;
            for (int k = 0; k < CDB_WIDTH; k++) begin
                r_cdb_prd[k]     <= w_lane_valid[k] ? w_lane_entry[k][EW-1 -: PREG_BITS] : '0;
                r_cdb_data[k]    <= w_lane_valid[k] ? w_lane_entry[k][38:7] : '0;
                r_cdb_rob_idx[k] <= w_lane_valid[k] ? w_lane_entry[k][6:0] : '0;
            end
        end
    end

    assign bus.cdb_valid    = r_cdb_valid;
    assign bus.cdb_prd      = r_cdb_prd;
    assign bus.cdb_data     = r_cdb_data;
    assign bus.cdb_rob_idx  = r_cdb_rob_idx;
    assign bus.overflow_err = r_overflow;
endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdb_arbiter
// Description : Random and directed stimulus against a queue-based reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;
    localparam int NS = 4, CW = 2, DEPTH = 8, SLACK = 5, PB = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    cdb_arbiter_if #(.PREG_BITS(PB), .NUM_SRC(NS), .CDB_WIDTH(CW)) bus ();

    cdb_arbiter #(
        .NUM_PHYS_REGS(64), .NUM_SRC(NS), .CDB_WIDTH(CW),
        .FIFO_DEPTH(DEPTH), .STALL_SLACK(SLACK)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PB-1:0] prd;
        logic [31:0]   data;
        logic [6:0]    rob;
    } ent_t;

    typedef struct {
        int   cyc;
        int   lane;
        ent_t e;
    } exp_t;

    ent_t mq [NS][$];
    exp_t expq [$];
    int   rr       = 0;
    bit   ovf      = 1'b0;
    int   edge_cnt = 0;
    int   checks   = 0;
    int   passed   = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    endtask

    // Reference: source queues served in rotating order, up to CW per cycle.
    task automatic model_step();
        int ng;
        int last;
        ng   = 0;
        last = 0;
        if (bus.flush) begin
            for (int s = 0; s < NS; s++) mq[s].delete();
            rr = 0;
            return;
        end
        for (int k = 0; k < NS; k++) begin
            int   idx;
            exp_t x;
            idx = (rr + k) % NS;
            if (mq[idx].size() > 0 && ng < CW) begin
                x.cyc  = edge_cnt + 1;
                x.lane = ng;
                x.e    = mq[idx].pop_front();
                expq.push_back(x);
                ng++;
                last = idx;
            end
        end
        if (ng > 0) rr = (last + 1) % NS;
        for (int s = 0; s < NS; s++) begin
            if (bus.src_valid[s]) begin
                ent_t e;
                e.prd  = bus.src_prd[s];
                e.data = bus.src_data[s];
                e.rob  = bus.src_rob_idx[s];
                if (mq[s].size() < DEPTH) mq[s].push_back(e);
                else ovf = 1'b1;
            end
        end
    endtask

    task automatic step(input logic [NS-1:0] v, input bit fl, input bit directed);
        @(negedge clk);
        bus.flush = fl;
        for (int s = 0; s < NS; s++) begin
            bus.src_valid[s]   = v[s];
            bus.src_prd[s]     = PB'($urandom);
            bus.src_data[s]    = $urandom;
            bus.src_rob_idx[s] = 7'($urandom);
        end
        if (directed) begin
            bus.src_prd[0] = PB'(5);  bus.src_data[0] = 32'h0000_1234; bus.src_rob_idx[0] = 7'd3;
            bus.src_prd[1] = PB'(9);  bus.src_data[1] = 32'hCAFE_0001; bus.src_rob_idx[1] = 7'd17;
        end
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, 1'b0, 1'b0);
    endtask

    // Monitor: samples just after each rising edge and matches lanes against the scoreboard.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < CW; k++) begin
                if (bus.cdb_valid[k]) begin
                    if (expq.size() > 0 && expq[0].cyc == edge_cnt && expq[0].lane == k) begin
                        exp_t x;
                        x = expq.pop_front();
                        chk($sformatf("lane%0d_prd", k),  64'(bus.cdb_prd[k]),     64'(x.e.prd));
                        chk($sformatf("lane%0d_data", k), 64'(bus.cdb_data[k]),    64'(x.e.data));
                        chk($sformatf("lane%0d_rob", k),  64'(bus.cdb_rob_idx[k]), 64'(x.e.rob));
                    end else begin
                        checks++;
                        $display("FAIL lane%0d_unexpected: got valid=1 data=%h required valid=0 (t=%0t)",
                                 k, bus.cdb_data[k], $time);
                    end
                end
            end
            while (expq.size() > 0 && expq[0].cyc <= edge_cnt) begin
                exp_t x;
                x = expq.pop_front();
                checks++;
                $display("FAIL lane%0d_missing: got valid=0 required valid=1 data=%h (t=%0t)",
                         x.lane, x.e.data, $time);
            end
            for (int s = 0; s < NS; s++) begin
                chk($sformatf("stall%0d", s), 64'(bus.src_stall[s]),
                    64'((DEPTH - mq[s].size()) <= SLACK));
            end
            chk("overflow_err", 64'(bus.overflow_err), 64'(ovf));
        end
    end

    initial begin
        bus.flush       = 1'b0;
        bus.src_valid   = '0;
        bus.src_prd     = '0;
        bus.src_data    = '0;
        bus.src_rob_idx = '0;
        #1;
        chk("reset_cdb_valid", 64'(bus.cdb_valid), 64'd0);
        chk("reset_cdb_data",  64'(bus.cdb_data),  64'd0);
        chk("reset_stall",     64'(bus.src_stall), 64'd0);
        chk("reset_overflow",  64'(bus.overflow_err), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single ALU0 result
        step(4'b0001, 1'b0, 1'b1);
        idle(4);
        // All sources for one cycle
        step(4'b1111, 1'b0, 1'b0);
        idle(4);
        // Three sources continuously
        for (int i = 0; i < 30; i++) step(4'b0111, 1'b0, 1'b0);
        idle(10);
        // All sources continuously until overflow
        for (int i = 0; i < 24; i++) step(4'b1111, 1'b0, 1'b0);
        chk("overflow_set", 64'(bus.overflow_err), 64'd1);
        idle(20);
        // Flush with queued entries and live inputs
        step(4'b0111, 1'b0, 1'b0);
        step(4'b0111, 1'b0, 1'b0);
        step(4'b1111, 1'b1, 1'b0);
        idle(4);
        chk("overflow_sticky", 64'(bus.overflow_err), 64'd1);

        // Random traffic with occasional flushes
        for (int i = 0; i < 300; i++) begin
            logic [NS-1:0] v;
            v = (i < 150) ? NS'($urandom & $urandom) : NS'($urandom);
            step(v, ($urandom_range(0, 39) == 0), 1'b0);
        end

        // Asynchronous reset mid-burst
        step(4'b1111, 1'b0, 1'b0);
        step(4'b1111, 1'b0, 1'b0);
        step(4'b1111, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        rst_n         = 1'b0;
        bus.src_valid = '0;
        bus.flush     = 1'b0;
        #1;
        chk("async_rst_cdb_valid", 64'(bus.cdb_valid),    64'd0);
        chk("async_rst_cdb_data",  64'(bus.cdb_data),     64'd0);
        chk("async_rst_stall",     64'(bus.src_stall),    64'd0);
        chk("async_rst_overflow",  64'(bus.overflow_err), 64'd0);
        for (int s = 0; s < NS; s++) mq[s].delete();
        expq.delete();
        rr  = 0;
        ovf = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b0010, 1'b0, 1'b1);
        idle(24);

        chk("scoreboard_drained", 64'(expq.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
`default_nettype wire
